// File: rtl/updi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : updi_pkg
// Description : Shared types and byte constants for the UPDI command
//               sequencer: command opcodes, error codes, FSM states and
//               the UPDI instruction byte values.
// Revision    : 1.0 - initial release
// ============================================================================
package updi_pkg;

    typedef enum logic [1:0] {
        OP_LDCS = 2'd0,
        OP_STCS = 2'd1,
        OP_LDS  = 2'd2,
        OP_STS  = 2'd3
    } updi_op_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_NACK    = 2'd2
    } updi_err_t;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_TX_SYNCH  = 4'd1,
        ST_TX_OPC    = 4'd2,
        ST_TX_ADDR_L = 4'd3,
        ST_TX_ADDR_H = 4'd4,
        ST_TX_DATA   = 4'd5,
        ST_RX_WAIT   = 4'd6,
        ST_GUARD     = 4'd7,
        ST_BREAK     = 4'd8,
        ST_RESP      = 4'd9
    } updi_state_t;

    localparam logic [7:0] UPDI_SYNCH    = 8'h55;
    localparam logic [7:0] UPDI_ACK      = 8'h40;
    localparam logic [7:0] OPC_LDCS      = 8'h80;
    localparam logic [7:0] OPC_STCS      = 8'hC0;
    localparam logic [7:0] OPC_LDS_B_A16 = 8'h04;
    localparam logic [7:0] OPC_STS_B_A16 = 8'h44;

    // Instruction byte sent after SYNCH; CS ops carry the register index
    // in the low nibble, memory ops use byte-data / 16-bit-address forms.
    function automatic logic [7:0] opcode_for(input updi_op_t op,
                                              input logic [3:0] cs_addr);
        logic [7:0] opc;
        case (op)
            OP_LDCS: opc = OPC_LDCS | {4'h0, cs_addr};
            OP_STCS: opc = OPC_STCS | {4'h0, cs_addr};
            OP_LDS:  opc = OPC_LDS_B_A16;
            default: opc = OPC_STS_B_A16;
        endcase
        return opc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/updi_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : updi_cycle_timer
// Description : Loadable down-counter shared by the RX wait, guard and
//               break phases of the UPDI sequencer.
//               Ports: i_clk, i_rstn (async active-low), i_load/i_load_val
//               (load N on this edge), o_zero (high during the last of the
//               N counted cycles, i.e. the count steps to zero at the next
//               edge). Loading N therefore yields an N-cycle window.
// Revision    : 1.0 - initial release
// ============================================================================
module updi_cycle_timer #(
    parameter int WIDTH = 13
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/updi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : updi_cmd_sequencer
// Description : Host-facing UPDI transaction engine. Runs one LDCS / STCS /
//               LDS / STS command at a time: streams SYNCH, opcode, address
//               and data bytes to the framer (valid/ready), waits for device
//               bytes, checks ACKs, enforces guard time and timeout, and
//               raises a line BREAK on failure before responding.
//               Ports: i_clk, i_rstn (async active-low); command i_cmd_*,
//               o_cmd_ready; TX byte stream o_tx_*/i_tx_ready; RX strobe
//               i_rx_*; response o_rsp_*; o_break level; o_busy.
//               Optional macro UPDI_RETRY_EN: one automatic retry of the
//               latched command after the first TIMEOUT/NACK break.
// Revision    : 1.0 - initial release
// ============================================================================
module updi_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GUARD_CYCLES   = 32,
    parameter int BREAK_CYCLES   = 2400
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_op,
    input  logic [15:0] i_cmd_addr,
    input  logic [7:0]  i_cmd_wdata,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rsp_valid,
    output logic [7:0]  o_rsp_data,
    output logic [1:0]  o_rsp_err,
    output logic        o_break,
    output logic        o_busy
);
    import updi_pkg::*;

    localparam int c_max_tg    = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
    localparam int c_max_cyc   = (c_max_tg > BREAK_CYCLES) ? c_max_tg : BREAK_CYCLES;
    localparam int c_tmr_w     = $clog2(c_max_cyc) + 1;
    localparam logic [c_tmr_w-1:0] c_ld_timeout = c_tmr_w'(TIMEOUT_CYCLES);
    localparam logic [c_tmr_w-1:0] c_ld_guard   = c_tmr_w'(GUARD_CYCLES);
    localparam logic [c_tmr_w-1:0] c_ld_break   = c_tmr_w'(BREAK_CYCLES);

    updi_state_t        r_state;
    updi_op_t           r_op;
    logic [15:0]        r_addr;
    logic [7:0]         r_wdata;
    logic [7:0]         r_rd_data;
    updi_err_t          r_err;
    logic               r_data_sent;   // STS: data byte already sent, next ACK is final
`ifdef UPDI_RETRY_EN
    logic               r_retried;
`endif

    logic               w_tx_fire;
    logic               w_nack;
    logic               w_tmr_load;
    logic [c_tmr_w-1:0] w_tmr_val;
    logic               w_tmr_zero;

    assign w_tx_fire = o_tx_valid && i_tx_ready;
    // Only STS has ACK phases; every byte it receives must be ACK.
    assign w_nack    = (r_op == OP_STS) && (i_rx_data != UPDI_ACK);

    // Timer is loaded on the same edge that enters RX_WAIT, GUARD or BREAK
    // so that each window starts counting in its first cycle.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = c_ld_timeout;
        case (r_state)
            ST_TX_OPC:    w_tmr_load = w_tx_fire && (r_op == OP_LDCS);
            ST_TX_ADDR_H: w_tmr_load = w_tx_fire;
            ST_TX_DATA:   w_tmr_load = w_tx_fire && (r_op == OP_STS);
            ST_RX_WAIT: begin
                if (i_rx_valid) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = w_nack ? c_ld_break : c_ld_guard;
                end else if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_ld_break;
                end
            end
            default: ;
        endcase
    end

    updi_cycle_timer #(
        .WIDTH (c_tmr_w)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_LDCS;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd_data   <= '0;
            r_err       <= ERR_OK;
            r_data_sent <= 1'b0;
`ifdef UPDI_RETRY_EN
            r_retried   <= 1'b0;
`endif
            o_cmd_ready <= 1'b1;
            o_tx_data   <= '0;
            o_tx_valid  <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_err   <= '0;
            o_break     <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_op        <= updi_op_t'(i_cmd_op);
                        r_addr      <= i_cmd_addr;
                        r_wdata     <= i_cmd_wdata;
                        r_rd_data   <= '0;
                        r_err       <= ERR_OK;
                        r_data_sent <= 1'b0;
`ifdef UPDI_RETRY_EN
                        r_retried   <= 1'b0;
`endif
                        o_cmd_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        o_tx_valid  <= 1'b1;
                        o_tx_data   <= UPDI_SYNCH;
                        r_state     <= ST_TX_SYNCH;
                    end
                end
                ST_TX_SYNCH: begin
                    if (w_tx_fire) begin
                        o_tx_data <= opcode_for(r_op, r_addr[3:0]);
                        r_state   <= ST_TX_OPC;
                    end
                end
                ST_TX_OPC: begin
                    if (w_tx_fire) begin
                        case (r_op)
                            OP_LDCS: begin
                                o_tx_valid <= 1'b0;
                                r_state    <= ST_RX_WAIT;
                            end
                            OP_STCS: begin
                                o_tx_data <= r_wdata;
                                r_state   <= ST_TX_DATA;
                            end
                            default: begin
                                o_tx_data <= r_addr[7:0];
                                r_state   <= ST_TX_ADDR_L;
                            end
                        endcase
                    end
                end
                ST_TX_ADDR_L: begin
                    if (w_tx_fire) begin
                        o_tx_data <= r_addr[15:8];
                        r_state   <= ST_TX_ADDR_H;
                    end
                end
                ST_TX_ADDR_H: begin
                    if (w_tx_fire) begin
                        o_tx_valid <= 1'b0;
                        r_state    <= ST_RX_WAIT;
                    end
                end
                ST_TX_DATA: begin
                    if (w_tx_fire) begin
                        o_tx_valid <= 1'b0;
                        if (r_op == OP_STCS) begin
                            // STCS is fire-and-forget: no ACK, no guard.
                            o_rsp_valid <= 1'b1;
                            o_rsp_data  <= r_rd_data;
                            o_rsp_err   <= r_err;
                            r_state     <= ST_RESP;
                        end else begin
                            r_data_sent <= 1'b1;
                            r_state     <= ST_RX_WAIT;
                        end
                    end
                end
                ST_RX_WAIT: begin
                    // A byte arriving in the final window cycle beats the timeout.
                    if (i_rx_valid) begin
                        if (w_nack) begin
                            r_err   <= ERR_NACK;
                            o_break <= 1'b1;
                            r_state <= ST_BREAK;
                        end else begin
                            if (r_op != OP_STS) begin
                                r_rd_data <= i_rx_data;
                            end
                            r_state <= ST_GUARD;
                        end
                    end else if (w_tmr_zero) begin
                        r_err   <= ERR_TIMEOUT;
                        o_break <= 1'b1;
                        r_state <= ST_BREAK;
                    end
                end
                ST_GUARD: begin
                    if (w_tmr_zero) begin
                        if ((r_op == OP_STS) && !r_data_sent) begin
                            o_tx_valid <= 1'b1;
                            o_tx_data  <= r_wdata;
                            r_state    <= ST_TX_DATA;
                        end else begin
                            o_rsp_valid <= 1'b1;
                            o_rsp_data  <= r_rd_data;
                            o_rsp_err   <= r_err;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_BREAK: begin
                    if (w_tmr_zero) begin
                        o_break <= 1'b0;
`ifdef UPDI_RETRY_EN
                        if (!r_retried) begin
                            // Silent second attempt of the same latched command.
                            r_retried   <= 1'b1;
                            r_err       <= ERR_OK;
                            r_data_sent <= 1'b0;
                            o_tx_valid  <= 1'b1;
                            o_tx_data   <= UPDI_SYNCH;
                            r_state     <= ST_TX_SYNCH;
                        end else begin
                            o_rsp_valid <= 1'b1;
                            o_rsp_data  <= r_rd_data;
                            o_rsp_err   <= r_err;
                            r_state     <= ST_RESP;
                        end
`else
                        o_rsp_valid <= 1'b1;
                        o_rsp_data  <= r_rd_data;
                        o_rsp_err   <= r_err;
                        r_state     <= ST_RESP;
`endif
                    end
                end
                ST_RESP: begin
                    o_rsp_valid <= 1'b0;
                    o_rsp_data  <= '0;
                    o_rsp_err   <= '0;
                    o_busy      <= 1'b0;
                    o_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_updi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_updi_cmd_sequencer
// Description : Self-checking bench for updi_cmd_sequencer. Expected TX
//               bytes and responses are queued as each command is issued
//               and compared by monitors as the DUT produces them.
//               Honours UPDI_RETRY_EN for the failure scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updi_cmd_sequencer;

    localparam int TIMEOUT_CYCLES = 4096;
    localparam int GUARD_CYCLES   = 32;
    localparam int BREAK_CYCLES   = 2400;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [1:0]  i_cmd_op;
    logic [15:0] i_cmd_addr;
    logic [7:0]  i_cmd_wdata;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rsp_valid;
    logic [7:0]  o_rsp_data;
    logic [1:0]  o_rsp_err;
    logic        o_break;
    logic        o_busy;

    updi_cmd_sequencer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .GUARD_CYCLES   (GUARD_CYCLES),
        .BREAK_CYCLES   (BREAK_CYCLES)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_op    (i_cmd_op),
        .i_cmd_addr  (i_cmd_addr),
        .i_cmd_wdata (i_cmd_wdata),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_err   (o_rsp_err),
        .o_break     (o_break),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] exp_tx[$];
    logic [9:0] exp_rsp[$];   // {err, data}

    int  ready_mode   = 0;    // 0: always ready, 1: toggling
    int  last_rx_cyc  = -1;
    int  strobe_cyc   = 0;
    int  rsp_seen     = 0;
    int  rsp_cyc      = 0;
    int  brk_len      = 0;
    int  brk_runs     = 0;
    int  stall_events = 0;
    bit  stall_pend   = 1'b0;
    logic [7:0] stall_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Framer ready generator.
    initial begin
        i_tx_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            if (ready_mode == 1) i_tx_ready = ~i_tx_ready;
            else                 i_tx_ready = 1'b1;
        end
    end

    // TX / response / break monitor, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (!i_rstn) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                chk("tx_valid_held", {31'd0, o_tx_valid}, 32'd1);
                chk("tx_data_held", {24'd0, o_tx_data}, {24'd0, stall_data});
            end
            stall_pend = o_tx_valid && !i_tx_ready;
            if (stall_pend) begin
                stall_data = o_tx_data;
                stall_events++;
            end
            if (o_tx_valid && i_tx_ready) begin
                if (exp_tx.size() == 0) begin
                    chk("tx_byte_expected", {24'd0, o_tx_data}, 32'h100);
                end else begin
                    logic [7:0] e;
                    e = exp_tx.pop_front();
                    chk("tx_byte", {24'd0, o_tx_data}, {24'd0, e});
                end
                if (last_rx_cyc >= 0) begin
                    chk("guard_gap",
                        (cyc - last_rx_cyc > GUARD_CYCLES) ? GUARD_CYCLES + 1 : cyc - last_rx_cyc,
                        GUARD_CYCLES + 1);
                end
            end
            if (o_rsp_valid) begin
                rsp_seen++;
                rsp_cyc = cyc;
                if (exp_rsp.size() == 0) begin
                    chk("rsp_expected", {22'd0, o_rsp_err, o_rsp_data}, 32'h400);
                end else begin
                    logic [9:0] r;
                    r = exp_rsp.pop_front();
                    chk("rsp_err", {30'd0, o_rsp_err}, {30'd0, r[9:8]});
                    chk("rsp_data", {24'd0, o_rsp_data}, {24'd0, r[7:0]});
                end
            end
            if (o_break) begin
                brk_len++;
            end else if (brk_len != 0) begin
                chk("break_len", brk_len, BREAK_CYCLES);
                brk_runs++;
                brk_len = 0;
            end
        end
    end

    initial begin
        repeat (90000) @(posedge i_clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] wd);
        int i;
        for (i = 0; i < 20000 && !o_cmd_ready; i++) begin
            @(posedge i_clk);
            #1;
        end
        chk("cmd_ready_before_issue", {31'd0, o_cmd_ready}, 32'd1);
        last_rx_cyc = -1;
        i_cmd_op    = op;
        i_cmd_addr  = addr;
        i_cmd_wdata = wd;
        i_cmd_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
    endtask

    // Returns in the first cycle after every queued TX byte has gone out.
    task automatic wait_tx_done(input int bound);
        int i;
        for (i = 0; i < bound && !(exp_tx.size() == 0 && !o_tx_valid); i++) begin
            @(posedge i_clk);
            #1;
        end
        if (i >= bound) chk("tx_drain_timeout", exp_tx.size(), 0);
    endtask

    task automatic rx_strobe(input logic [7:0] b, input int delay);
        repeat (delay) @(posedge i_clk);
        if (delay != 0) #1;
        i_rx_data   = b;
        i_rx_valid  = 1'b1;
        last_rx_cyc = cyc;
        strobe_cyc  = cyc;
        @(posedge i_clk);
        #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int bound);
        int start;
        int i;
        start = rsp_seen;
        for (i = 0; i < bound && rsp_seen == start; i++) begin
            @(posedge i_clk);
            #1;
        end
        chk("rsp_count", rsp_seen - start, 1);
        chk("idle_after_rsp", {30'd0, o_cmd_ready, o_busy}, 32'd2);
        chk("tx_all_sent", exp_tx.size(), 0);
    endtask

    initial begin
        int brk0;
        int rx_entry;
        int i;
        i_rstn      = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_op    = 2'd0;
        i_cmd_addr  = 16'h0;
        i_cmd_wdata = 8'h0;
        i_rx_data   = 8'h0;
        i_rx_valid  = 1'b0;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
        chk("rst_outputs", {o_tx_valid, o_rsp_valid, o_break, o_busy, o_rsp_err, o_tx_data, o_rsp_data}, 32'd0);
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;

        // LDCS CS0, reply 0x30 after 100 cycles; response GUARD+1 after strobe
        exp_tx.push_back(8'h55); exp_tx.push_back(8'h80);
        exp_rsp.push_back({2'd0, 8'h30});
        issue(2'd0, 16'h0000, 8'h00);
        wait_tx_done(50);
        rx_strobe(8'h30, 100);
        wait_rsp(200);
        chk("ldcs_latency", rsp_cyc - strobe_cyc, GUARD_CYCLES + 1);

        // STS 0x1234 <- 0xA5, two ACKs; guard gap checked by monitor
        exp_tx.push_back(8'h55); exp_tx.push_back(8'h44);
        exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
        exp_rsp.push_back({2'd0, 8'h00});
        issue(2'd3, 16'h1234, 8'hA5);
        wait_tx_done(50);
        rx_strobe(8'h40, 10);
        exp_tx.push_back(8'hA5);
        wait_tx_done(100);
        rx_strobe(8'h40, 5);
        wait_rsp(200);

        // LDS 0x0F00 with a stalling framer
        ready_mode   = 1;
        stall_events = 0;
        exp_tx.push_back(8'h55); exp_tx.push_back(8'h04);
        exp_tx.push_back(8'h00); exp_tx.push_back(8'h0F);
        exp_rsp.push_back({2'd0, 8'h1E});
        issue(2'd2, 16'h0F00, 8'h00);
        wait_tx_done(100);
        ready_mode = 0;
        chk("stall_exercised", {31'd0, stall_events != 0}, 32'd1);
        rx_strobe(8'h1E, 20);
        wait_rsp(200);

        // STS with NACK on the first ACK
        brk0 = brk_runs;
        exp_tx.push_back(8'h55); exp_tx.push_back(8'h44);
        exp_tx.push_back(8'h02); exp_tx.push_back(8'h01);
`ifdef UPDI_RETRY_EN
        exp_rsp.push_back({2'd0, 8'h00});
`else
        exp_rsp.push_back({2'd2, 8'h00});
`endif
        issue(2'd3, 16'h0102, 8'h77);
        wait_tx_done(50);
        rx_strobe(8'h00, 3);
`ifdef UPDI_RETRY_EN
        exp_tx.push_back(8'h55); exp_tx.push_back(8'h44);
        exp_tx.push_back(8'h02); exp_tx.push_back(8'h01);
        wait_tx_done(BREAK_CYCLES + 200);
        rx_strobe(8'h40, 3);
        exp_tx.push_back(8'h77);
        wait_tx_done(100);
        rx_strobe(8'h40, 3);
`endif
        wait_rsp(BREAK_CYCLES + 200);
        chk("nack_break_runs", brk_runs - brk0, 1);

        // LDCS with no reply: timeout window, break, err=TIMEOUT
        brk0 = brk_runs;
        exp_tx.push_back(8'h55); exp_tx.push_back(8'h83);
`ifdef UPDI_RETRY_EN
        exp_tx.push_back(8'h55); exp_tx.push_back(8'h83);
`endif
        exp_rsp.push_back({2'd1, 8'h00});
        issue(2'd0, 16'h0003, 8'h00);
        wait_tx_done(50);
        rx_entry = cyc;
        for (i = 0; i < TIMEOUT_CYCLES + 100 && !o_break; i++) begin
            @(posedge i_clk);
            #1;
        end
        chk("timeout_window", cyc - rx_entry, TIMEOUT_CYCLES);
        wait_rsp(2 * (TIMEOUT_CYCLES + BREAK_CYCLES) + 500);
`ifdef UPDI_RETRY_EN
        chk("timeout_break_runs", brk_runs - brk0, 2);
`else
        chk("timeout_break_runs", brk_runs - brk0, 1);
`endif

        // Byte on the last cycle of the timeout window wins
        brk0 = brk_runs;
        exp_tx.push_back(8'h55); exp_tx.push_back(8'h81);
        exp_rsp.push_back({2'd0, 8'h5A});
        issue(2'd0, 16'h0001, 8'h00);
        wait_tx_done(50);
        rx_strobe(8'h5A, TIMEOUT_CYCLES - 1);
        wait_rsp(200);
        chk("last_cycle_no_break", brk_runs - brk0, 0);

        // Reset during TX_ADDR_H aborts silently
        brk0 = brk_runs;
        exp_tx.push_back(8'h55); exp_tx.push_back(8'h04);
        exp_tx.push_back(8'hCD); exp_tx.push_back(8'hAB);
        issue(2'd2, 16'hABCD, 8'h00);
        for (i = 0; i < 50 && !(o_tx_valid && o_tx_data == 8'hAB); i++) begin
            @(posedge i_clk);
            #1;
        end
        i_rstn = 1'b0;
        #1;
        chk("midrst_outputs", {o_tx_valid, o_rsp_valid, o_break, o_busy, o_rsp_err, o_tx_data, o_rsp_data}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
        chk("midrst_unsent", exp_tx.size(), 1);
        exp_tx.delete();
        repeat (3) @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;
        chk("postrst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
        exp_tx.push_back(8'h55); exp_tx.push_back(8'h82);
        exp_rsp.push_back({2'd0, 8'h99});
        issue(2'd0, 16'h0002, 8'h00);
        wait_tx_done(50);
        rx_strobe(8'h99, 7);
        wait_rsp(200);

        // STCS 0x5 <- 0x3C: response right after the data byte
        exp_tx.push_back(8'h55); exp_tx.push_back(8'hC5); exp_tx.push_back(8'h3C);
        exp_rsp.push_back({2'd0, 8'h00});
        issue(2'd1, 16'h0005, 8'h3C);
        wait_rsp(50);

        repeat (50) @(posedge i_clk);
        #1;
        chk("no_stray_rsp", exp_rsp.size(), 0);
        chk("no_stray_break", brk_runs - brk0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/updi_cmd_sequencer.md
Name: updi_cmd_sequencer

Overview:
Host-facing command engine that sequences the UPDI byte-frame generator for one transaction at a time: LDCS, STCS, LDS and STS, with byte data and a 16-bit address. It emits SYNCH/opcode/address/data bytes over a valid/ready byte stream into the framer. It then waits for device bytes from the UART receiver, checks ACKs, enforces guard time and timeout, and requests a line BREAK on failure. It sits between the debug host logic and the framer/receiver pair.

Parameters:
TIMEOUT_CYCLES, 4096, max i_clk cycles waiting for a device byte in RX_WAIT
GUARD_CYCLES, 32, idle cycles required after a received byte before the next TX byte
BREAK_CYCLES, 2400, cycles o_break is held high after a timeout or NACK

Ports:
i_clk  in  1  single clock; all logic on posedge
i_rstn  in  1  asynchronous active-low reset
i_cmd_valid  in  1  command request
o_cmd_ready  out  1  high only in IDLE
i_cmd_op  in  2  0=LDCS 1=STCS 2=LDS 3=STS
i_cmd_addr  in  16  CS address in [3:0] for LDCS/STCS; memory address for LDS/STS
i_cmd_wdata  in  8  write data for STCS/STS
o_tx_data  out  8  byte to framer
o_tx_valid  out  1  byte valid; o_tx_data is stable while valid && !ready
i_tx_ready  in  1  framer accepts byte
i_rx_data  in  8  device byte; echo is already filtered by the receiver
i_rx_valid  in  1  one-cycle strobe
o_rsp_valid  out  1  one-cycle completion pulse; no backpressure
o_rsp_data  out  8  read data (LDCS/LDS), 0 otherwise
o_rsp_err  out  2  0=OK 1=TIMEOUT 2=NACK
o_break  out  1  break request level
o_busy  out  1  state != IDLE

Behaviour:
- Reset (async, i_rstn low): state=IDLE, all outputs 0 except o_cmd_ready=1; all counters and latches 0. Reset mid-transaction aborts silently: no rsp and no break.
- Command capture: on i_cmd_valid && o_cmd_ready, latch op/addr/wdata and go to TX_SYNCH.
- TX byte transfer: occurs on o_tx_valid && i_tx_ready; the state advances the cycle after the transfer.
- States: IDLE, TX_SYNCH, TX_OPC, TX_ADDR_L, TX_ADDR_H, TX_DATA, RX_WAIT, GUARD, BREAK, RESP.
- Bytes per op:
  - SYNCH=8'h55 always first.
  - LDCS: opcode 8'h80|addr[3:0], then RX_WAIT for data.
  - STCS: opcode 8'hC0|addr[3:0], then TX_DATA; no ACK.
  - LDS: opcode 8'h04, ADDR_L, ADDR_H, then RX_WAIT for data.
  - STS: opcode 8'h44, ADDR_L, ADDR_H, RX_WAIT for ACK, GUARD, TX_DATA, RX_WAIT for ACK.
- RX_WAIT:
  - Timeout counter loads TIMEOUT_CYCLES on entry and decrements each cycle.
  - i_rx_valid on the same cycle as the counter reaching 0: the byte wins.
  - Counter reaching 0 with no byte: err=TIMEOUT, go to BREAK.
  - An ACK phase receiving a byte other than 8'h40: err=NACK, go to BREAK.
  - The final read byte is latched into o_rsp_data.
- GUARD: counts GUARD_CYCLES with o_tx_valid=0 after every received byte, including the final one, before continuing or entering RESP.
- i_rx_valid outside RX_WAIT is ignored.
- BREAK: o_break=1 for exactly BREAK_CYCLES cycles, then RESP.
- RESP: o_rsp_valid=1 for one cycle with data/err, then IDLE.
- STCS completes with RESP directly after the TX_DATA transfer (err=0, data=0).
- Latency, LDCS with a zero-wait framer: 2 TX cycles + rx wait + GUARD_CYCLES + 1.

Optional Feature:
UPDI_RETRY_EN
- Defined: after the first BREAK caused by TIMEOUT or NACK, restart once from TX_SYNCH with the same latched command, with no RESP in between. Report the error only if the second attempt also fails; a retry flag resets per command.
- Undefined: the first failure goes BREAK -> RESP with the error.

Decomposition:
- updi_pkg:
  - op enum (LDCS/STCS/LDS/STS)
  - err enum
  - state enum
  - constants: UPDI_SYNCH=8'h55, UPDI_ACK=8'h40, OPC_LDCS=8'h80, OPC_STCS=8'hC0, OPC_LDS_B_A16=8'h04, OPC_STS_B_A16=8'h44
- One sub-module, updi_cycle_timer: a loadable down-counter with a zero flag, sized $clog2 of the largest of TIMEOUT/GUARD/BREAK plus 1, shared by RX_WAIT, GUARD and BREAK.

Test Plan:
- LDCS addr=4'h0, device returns 8'h30 after 100 cycles -> TX 55,80; rsp_valid with data=30, err=0 exactly GUARD_CYCLES+1 cycles after the rx strobe.
- STS addr=16'h1234 wdata=8'hA5, ACKs 40/40 -> TX 55,44,34,12, then A5 only after ≥32 idle cycles; rsp err=0, data=0.
- LDS addr=16'h0F00 with i_tx_ready toggling every other cycle -> o_tx_data is held stable while stalled; byte order 55,04,00,0F; returned byte 8'h1E is reported.
- STS where the first ACK is 8'h00 -> NACK; o_break high for exactly 2400 cycles; rsp err=2 (with UPDI_RETRY_EN: the full sequence repeats once, and a good second attempt gives err=0).
- LDCS with no device reply -> timeout after 4096 cycles, break, then rsp err=1; rx strobe landing on the final cycle is accepted as data instead.
- i_rstn asserted during TX_ADDR_H -> outputs 0 asynchronously, no rsp; after release o_cmd_ready=1 and a new command runs normally.
